glip_uart_egress_sched: RTL and testbench



---
 rtl/glip_uart_egress_sched.sv | 169 ++++++++++++++++
 tb/tb_glip_uart_egress_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_uart_egress_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | glip_uart_egress_sched: arbitrates payload bytes and credit frames onto the |
// | UART TX byte port. Optional stats: GLIP_UART_EGRESS_SCHED_STATS_EN. Rev 1.0 |
// +-----------------------------------------------------------------------------+
module glip_uart_egress_sched #(
   parameter logic [7:0] ESC          = 8'hFE,
   parameter int         CREDIT_WIDTH = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    can_send,
   input  logic [CREDIT_WIDTH-1:0] credit,
   input  logic                    credit_en,
   output logic                    credit_ack,
   output logic [7:0]              out_data,
   output logic                    out_enable,
   input  logic                    out_done,
   output logic                    transfer,
   output logic                    error
`ifdef GLIP_UART_EGRESS_SCHED_STATS_EN
   ,
   output logic [31:0]             stat_data_bytes,
   output logic [15:0]             stat_credit_frames
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_BYTE = 3'd1,
      D_ESC2 = 3'd2,
      C_ESC  = 3'd3,
      C_HI   = 3'd4,
      C_LO   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_out_data;
   logic [7:0]  w_out_data_nxt;
   logic        r_out_en;
   logic        w_out_en_nxt;
   logic [14:0] r_credit;
   logic [14:0] w_credit_nxt;
   logic [14:0] w_credit_ext;
   logic        r_error;
   logic        w_err_evt;
   logic        w_in_ready;
   logic        w_transfer;
   logic        w_ack;
   logic        w_in_credit;

   always_comb begin
      w_credit_ext                   = '0;
      w_credit_ext[CREDIT_WIDTH-1:0] = credit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_out_data <= '0;
         r_out_en   <= 1'b0;
         r_credit   <= '0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_out_data <= w_out_data_nxt;
         r_out_en   <= w_out_en_nxt;
         r_credit   <= w_credit_nxt;
         r_error    <= r_error | w_err_evt;
      end
   end

   // Doubled ESC reuses D_BYTE for its second byte, so transfer fires only there.
   always_comb begin
      w_state_nxt    = r_state;
      w_out_data_nxt = r_out_data;
      w_out_en_nxt   = r_out_en;
      w_credit_nxt   = r_credit;
      w_in_ready     = 1'b0;
      w_transfer     = 1'b0;
      w_ack          = 1'b0;
      case (r_state)
         IDLE: begin
            if (credit_en) begin
               w_credit_nxt   = w_credit_ext;
               w_out_data_nxt = ESC;
               w_out_en_nxt   = 1'b1;
               w_state_nxt    = C_ESC;
            end else if (in_valid && can_send) begin
               w_in_ready     = 1'b1;
               w_out_data_nxt = in_data;
               w_out_en_nxt   = 1'b1;
               w_state_nxt    = (in_data == ESC) ? D_ESC2 : D_BYTE;
            end
         end
         D_BYTE: begin
            if (out_done) begin
               w_out_en_nxt = 1'b0;
               w_transfer   = 1'b1;
               w_state_nxt  = IDLE;
            end
         end
         D_ESC2: begin
            if (out_done) begin
               w_out_data_nxt = ESC;
               w_state_nxt    = D_BYTE;
            end
         end
         C_ESC: begin
            if (out_done) begin
               w_out_data_nxt = {1'b0, r_credit[14:8]};
               w_state_nxt    = C_HI;
            end
         end
         C_HI: begin
            if (out_done) begin
               w_out_data_nxt = r_credit[7:0];
               w_state_nxt    = C_LO;
            end
         end
         C_LO: begin
            if (out_done) begin
               w_out_en_nxt = 1'b0;
               w_ack        = 1'b1;
               w_state_nxt  = IDLE;
            end
         end
         default: begin
            w_out_en_nxt = 1'b0;
            w_state_nxt  = IDLE;
         end
      endcase
   end

   assign w_in_credit = (r_state == C_ESC) || (r_state == C_HI) || (r_state == C_LO);
   assign w_err_evt   = (out_done && !r_out_en) || (w_in_credit && !credit_en);

   // Pulses are masked during reset so an aborted frame never reports completion.
   assign in_ready   = w_in_ready & rst_n;
   assign transfer   = w_transfer & rst_n;
   assign credit_ack = w_ack & rst_n;
   assign out_data   = r_out_data;
   assign out_enable = r_out_en;
   assign error      = r_error;

`ifdef GLIP_UART_EGRESS_SCHED_STATS_EN
   logic [31:0] r_stat_data;
   logic [15:0] r_stat_credit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_data   <= '0;
         r_stat_credit <= '0;
      end else begin
         if (w_transfer) r_stat_data <= r_stat_data + 32'd1;
         if (w_ack)      r_stat_credit <= r_stat_credit + 16'd1;
      end
   end

   assign stat_data_bytes    = r_stat_data;
   assign stat_credit_frames = r_stat_credit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_glip_uart_egress_sched.sv
`default_nettype none
// Scoreboard bench: stimulus queues expected wire bytes, a monitor checks them on out_done.
module tb_glip_uart_egress_sched;

   typedef struct packed {
      logic [7:0] data;
      logic       xfer;
      logic       ack;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        can_send;
   logic [14:0] credit;
   logic        credit_en;
   logic        credit_ack;
   logic [7:0]  out_data;
   logic        out_enable;
   logic        out_done;
   logic        transfer;
   logic        error;
`ifdef GLIP_UART_EGRESS_SCHED_STATS_EN
   logic [31:0] stat_data_bytes;
   logic [15:0] stat_credit_frames;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_done = 0, n_xfer = 0, n_ack = 0, n_rdy = 0, n_rdy_bad = 0;
   int   drv_cnt = 0;
   bit   tx_auto = 1'b0;
   bit   spur = 1'b0;

   always #5 clk = ~clk;

   glip_uart_egress_sched #(.ESC(8'hFE), .CREDIT_WIDTH(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .can_send  (can_send),
      .credit    (credit),
      .credit_en (credit_en),
      .credit_ack(credit_ack),
      .out_data  (out_data),
      .out_enable(out_enable),
      .out_done  (out_done),
      .transfer  (transfer),
      .error     (error)
`ifdef GLIP_UART_EGRESS_SCHED_STATS_EN
      ,
      .stat_data_bytes   (stat_data_bytes),
      .stat_credit_frames(stat_credit_frames)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Transmitter model: out_done one cycle, 4 cycles after each byte is presented.
   initial begin
      out_done = 1'b0;
      forever begin
         @(negedge clk);
         if (out_done) out_done = 1'b0;
         else if (spur) begin
            out_done = 1'b1;
            spur     = 1'b0;
         end else if (tx_auto && rst_n && out_enable) begin
            drv_cnt++;
            if (drv_cnt >= 4) begin
               out_done = 1'b1;
               drv_cnt  = 0;
            end
         end else drv_cnt = 0;
      end
   end

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (in_ready) begin
               n_rdy++;
               if (credit_en || !can_send) n_rdy_bad++;
            end
            if (transfer)   n_xfer++;
            if (credit_ack) n_ack++;
            if (out_done && out_enable) begin
               n_done++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte actual=%0h required=none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("wire_byte", {24'd0, out_data}, {24'd0, e.data});
                  check("transfer_pulse", {31'd0, transfer}, {31'd0, e.xfer});
                  check("credit_ack_pulse", {31'd0, credit_ack}, {31'd0, e.ack});
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [7:0] d, input logic x, input logic a);
      exp_t e;
      e.data = d;
      e.xfer = x;
      e.ack  = a;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((exp_q.size() != 0 || out_enable) && k < 500) begin
         @(negedge clk);
         k++;
      end
      check(name, {31'd0, (k < 500)}, 32'd1);
   endtask

   task automatic send_data(input logic [7:0] b);
      int k = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      #1;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("in_ready_seen", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done_after(input int base);
      int k = 0;
      while (n_done == base && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("done_wait", {31'd0, (k < 200)}, 32'd1);
   endtask

   task automatic wait_ack_after(input int base);
      int k = 0;
      while (n_ack == base && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("ack_wait", {31'd0, (k < 200)}, 32'd1);
   endtask

   initial begin
      int bad;
      int a0;
      int d0;
      int k;
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; can_send = 1'b1;
      credit = '0; credit_en = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_enable", {31'd0, out_enable}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      tx_auto = 1'b1;

      // Plain byte
      push(8'h41, 1'b1, 1'b0);
      send_data(8'h41);
      wait_idle("t1_idle");
      check("t1_xfer_count", n_xfer, 1);
      check("t1_ready_count", n_rdy, 1);

      // Literal ESC is doubled
      push(8'hFE, 1'b0, 1'b0);
      push(8'hFE, 1'b1, 1'b0);
      send_data(8'hFE);
      wait_idle("t2_idle");
      check("t2_xfer_count", n_xfer, 2);
      check("t2_ack_count", n_ack, 0);

      // Credit beats a simultaneous data request; credit change mid-frame ignored
      push(8'hFE, 1'b0, 1'b0);
      push(8'h12, 1'b0, 1'b0);
      push(8'h34, 1'b0, 1'b1);
      push(8'h55, 1'b1, 1'b0);
      @(negedge clk);
      credit = 15'h1234; credit_en = 1'b1; in_data = 8'h55; in_valid = 1'b1;
      d0 = n_done;
      wait_done_after(d0);
      credit = 15'h7FFF;
      a0 = n_ack;
      wait_ack_after(a0);
      credit_en = 1'b0;
      #1;
      k = 0;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("t3_data_after_credit", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle("t3_idle");
      check("t3_ack_count", n_ack, 1);
      check("t3_xfer_count", n_xfer, 3);
      check("t3_ready_count", n_rdy, 3);
      check("ready_while_blocked", n_rdy_bad, 0);

      // No credit from host blocks payload
      @(negedge clk);
      can_send = 1'b0; in_data = 8'h33; in_valid = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         #1;
         if (in_ready || out_enable) bad++;
      end
      check("t4_blocked", bad, 0);
      push(8'h33, 1'b1, 1'b0);
      @(negedge clk);
      can_send = 1'b1;
      #1;
      check("t4_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("t4_latency_enable", {31'd0, out_enable}, 32'd1);
      check("t4_latency_data", {24'd0, out_data}, 32'h33);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle("t4_idle");
      check("t4_xfer_count", n_xfer, 4);

      // Reset mid credit frame, then full resend
      push(8'hFE, 1'b0, 1'b0);
      push(8'h0A, 1'b0, 1'b0);
      push(8'hBC, 1'b0, 1'b1);
      @(negedge clk);
      credit = 15'h0ABC; credit_en = 1'b1;
      a0 = n_ack;
      d0 = n_done;
      wait_done_after(d0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("t5_rst_out_enable", {31'd0, out_enable}, 32'd0);
      check("t5_rst_out_data", {24'd0, out_data}, 32'd0);
      check("t5_rst_ack", {31'd0, credit_ack}, 32'd0);
      check("t5_rst_transfer", {31'd0, transfer}, 32'd0);
      check("t5_rst_ack_count", n_ack, a0);
      exp_q.delete();
      push(8'hFE, 1'b0, 1'b0);
      push(8'h0A, 1'b0, 1'b0);
      push(8'hBC, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ack_after(a0);
      credit_en = 1'b0;
      wait_idle("t5_idle");
      check("t5_ack_count", n_ack, a0 + 1);
      check("error_clean", {31'd0, error}, 32'd0);

      // Spurious out_done in IDLE is a sticky error
      @(negedge clk);
      spur = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("t6_spurious_error", {31'd0, error}, 32'd1);
      repeat (10) @(negedge clk);
      #1;
      check("t6_error_sticky", {31'd0, error}, 32'd1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("t6_error_reset", {31'd0, error}, 32'd0);
      rst_n = 1'b1;

      // credit_en dropped during C_HI
      push(8'hFE, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b0);
      push(8'h01, 1'b0, 1'b1);
      @(negedge clk);
      credit = 15'h0001; credit_en = 1'b1;
      d0 = n_done;
      wait_done_after(d0);
      credit_en = 1'b0;
      @(negedge clk);
      #1;
      check("t6_drop_credit_error", {31'd0, error}, 32'd1);
      tx_auto = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst_n = 1'b1;
      check("final_ready_blocked", n_rdy_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
